// File: rtl/aes_dec_key_sched_if.sv
// Key-load / round-key stream bundle for aes_dec_key_sched.
// The slave side is the key scheduler; the master side is its client.
interface aes_dec_key_sched_if;
  logic [127:0] key_in;
  logic         key_load;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;

  modport master (output key_in, key_load, rk_ready,
                  input  busy, rk_valid, rk_data, rk_round, rk_last);
  modport slave  (input  key_in, key_load, rk_ready,
                  output busy, rk_valid, rk_data, rk_round, rk_last);
endinterface

// File: rtl/aes_dec_key_sched.sv
// Iterative AES-128 key expander: one round key per cycle into an 11-entry store,
// then streams keys round 10 -> 0. Optional KS_ZEROIZE_EN wipes the store after the last beat.
module aes_dec_key_sched #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_dec_key_sched_if.slave   ks
);

  if (NR != 10 || KEY_W != 128) begin : g_param_chk
    $error("aes_dec_key_sched: only NR=10, KEY_W=128 are supported");
  end

  localparam logic [3:0] LAST = 4'(NR);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_STREAM} state_t;

  state_t           r_state, w_next;
  logic [KEY_W-1:0] r_store [0:NR];
  logic [3:0]       r_cnt;
  logic [3:0]       r_ptr;
  logic [7:0]       r_rcon;
  logic             r_valid;
  logic             w_accept;
  logic [KEY_W-1:0] w_prev_key;
  logic [KEY_W-1:0] w_next_key;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // RotWord folded into the byte order of the lookup
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = sub_rot(k[31:0]) ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign w_accept   = r_valid & ks.rk_ready;
  assign w_prev_key = r_store[r_cnt - 4'd1];
  assign w_next_key = next_key(w_prev_key, r_rcon);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (ks.key_load)              w_next = S_EXPAND;
      S_EXPAND: if (r_cnt == LAST)            w_next = S_STREAM;
      S_STREAM: if (w_accept && r_ptr == 4'd0) w_next = S_IDLE;
      default:                                w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_rcon  <= '0;
      r_valid <= 1'b0;
      for (int i = 0; i <= NR; i++) r_store[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (ks.key_load) begin
          r_store[0] <= ks.key_in;
          r_rcon     <= 8'h01;
          r_cnt      <= 4'd1;
        end
        S_EXPAND: begin
          r_store[r_cnt] <= w_next_key;
          r_rcon         <= xtime(r_rcon);
          r_cnt          <= r_cnt + 4'd1;
          if (r_cnt == LAST) r_ptr <= LAST;
        end
        S_STREAM: begin
          // first STREAM cycle registers valid, giving the extra cycle of latency
          if (!r_valid) r_valid <= 1'b1;
          else if (w_accept) begin
            if (r_ptr == 4'd0) begin
              r_valid <= 1'b0;
`ifdef KS_ZEROIZE_EN
              for (int i = 0; i <= NR; i++) r_store[i] <= '0;
`endif
            end else begin
              r_ptr <= r_ptr - 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ks.busy     = (r_state != S_IDLE);
  assign ks.rk_valid = r_valid;
  assign ks.rk_round = r_ptr;
  assign ks.rk_last  = r_valid & (r_ptr == 4'd0);
`ifdef KS_ZEROIZE_EN
  assign ks.rk_data  = r_valid ? r_store[r_ptr] : '0;
`else
  assign ks.rk_data  = r_store[r_ptr];
`endif

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Scoreboard bench for aes_dec_key_sched: independent GF(2^8) S-box model, expected beats queued at load.
module tb_aes_dec_key_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_dec_key_sched_if u_if();
  aes_dec_key_sched dut (.clk(clk), .rst_n(rst_n), .ks(u_if));

  typedef struct {
    logic [127:0] d;
    logic [3:0]   r;
    logic         l;
  } exp_t;

  localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K1_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K2_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  exp_t         sb[$];
  int           n_chk = 0;
  int           n_pass = 0;
  int           n_beats = 0;
  logic [127:0] cap [0:10];
  logic [7:0]   sbx [0:255];
  bit           prev_stall = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a, y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from field inverse + affine map, independent of any lookup table
  task automatic init_sbox();
    logic [7:0] inv;
    sbx[0] = 8'h63;
    for (int x = 1; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbx[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic push_sched(input logic [127:0] k);
    logic [127:0] rk [0:10];
    logic [31:0]  t, a, b, c, d, w3;
    logic [7:0]   rc;
    exp_t         e;
    rk[0] = k;
    rc = 8'h01;
    for (int i = 1; i <= 10; i++) begin
      w3 = rk[i-1][31:0];
      t  = {sbx[w3[23:16]], sbx[w3[15:8]], sbx[w3[7:0]], sbx[w3[31:24]]} ^ {rc, 24'h0};
      a  = rk[i-1][127:96] ^ t;
      b  = rk[i-1][95:64]  ^ a;
      c  = rk[i-1][63:32]  ^ b;
      d  = rk[i-1][31:0]   ^ c;
      rk[i] = {a, b, c, d};
      rc = xt(rc);
    end
    for (int i = 10; i >= 0; i--) begin
      e.d = rk[i];
      e.r = 4'(i);
      e.l = (i == 0);
      sb.push_back(e);
    end
  endtask

  // caller sits 1ns after a rising edge; the next edge samples the load
  task automatic do_load(input logic [127:0] k, input bit acc);
    u_if.key_in   = k;
    u_if.key_load = 1'b1;
    @(posedge clk); #1;
    u_if.key_load = 1'b0;
    if (acc) push_sched(k);
  endtask

  task automatic run_done(input bit rnd, input int budget);
    int c = 0;
    while (u_if.busy && c < budget) begin
      @(posedge clk); #1;
      if (rnd) u_if.rk_ready = 1'($urandom_range(0, 1));
      c++;
    end
    chk("done_timeout", 128'(u_if.busy), 128'(0));
  endtask

  task automatic wait_last(input int budget);
    int c = 0;
    while (!(u_if.rk_valid && u_if.rk_last) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk("last_timeout", 128'(u_if.rk_valid && u_if.rk_last), 128'(1));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  128'(u_if.busy),     128'(0));
    chk({tag, "_valid"}, 128'(u_if.rk_valid), 128'(0));
    chk({tag, "_last"},  128'(u_if.rk_last),  128'(0));
    chk({tag, "_round"}, 128'(u_if.rk_round), 128'(0));
    chk({tag, "_data"},  u_if.rk_data,        128'(0));
  endtask

  task automatic clr_cap();
    for (int i = 0; i <= 10; i++) cap[i] = '0;
    n_beats = 0;
  endtask

  // every presented beat must match the queue head, including during stalls
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (prev_stall) chk("no_retract", 128'(u_if.rk_valid), 128'(1));
      if (u_if.rk_valid) begin
        if (sb.size() == 0) chk("sb_empty", 128'(1), 128'(0));
        else begin
          chk("rk_data",  u_if.rk_data,         sb[0].d);
          chk("rk_round", 128'(u_if.rk_round),  128'(sb[0].r));
          chk("rk_last",  128'(u_if.rk_last),   128'(sb[0].l));
          if (u_if.rk_ready) begin
            if (u_if.rk_round <= 4'd10) cap[u_if.rk_round] = u_if.rk_data;
            n_beats++;
            void'(sb.pop_front());
          end
        end
      end
      prev_stall = u_if.rk_valid & ~u_if.rk_ready;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int lat;
    u_if.key_in   = '0;
    u_if.key_load = 1'b0;
    u_if.rk_ready = 1'b0;
    init_sbox();
    clr_cap();

    #12;
    chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // nominal stream, ready held high
    u_if.rk_ready = 1'b1;
    do_load(K1, 1'b1);
    chk("busy_on_load", 128'(u_if.busy), 128'(1));
    lat = 0;
    while (!u_if.rk_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency", 128'(lat), 128'(11));
    while (u_if.busy && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("load_to_done", 128'(lat), 128'(22));
    chk("beats_a", 128'(n_beats), 128'(11));
    chk("a_r10", cap[10], K1_10);
    chk("a_r1",  cap[1],  K1_1);
    chk("a_r0",  cap[0],  K1);
`ifdef KS_ZEROIZE_EN
    chk("idle_data", u_if.rk_data, 128'(0));
    for (int i = 0; i <= 10; i++) chk("store_zero", dut.r_store[i], 128'(0));
`else
    chk("idle_data", u_if.rk_data, K1);
`endif

    // random back-pressure
    clr_cap();
    u_if.rk_ready = 1'b0;
    do_load(K1, 1'b1);
    run_done(1'b1, 400);
    chk("beats_b", 128'(n_beats), 128'(11));
    chk("b_r10", cap[10], K1_10);
    chk("b_r1",  cap[1],  K1_1);
    chk("b_r0",  cap[0],  K1);

    // loads while busy are ignored
    clr_cap();
    u_if.rk_ready = 1'b1;
    do_load(K1, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    do_load(K2, 1'b0);
    chk("busy_ign_exp", 128'(u_if.busy), 128'(1));
    lat = 0;
    while (!u_if.rk_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    repeat (2) begin @(posedge clk); #1; end
    do_load(K2, 1'b0);
    chk("busy_ign_str", 128'(u_if.busy), 128'(1));
    run_done(1'b0, 40);
    chk("beats_c", 128'(n_beats), 128'(11));
    chk("c_r10", cap[10], K1_10);

    // reset mid-expand
    do_load(K1, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_exp");
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // reset mid-stream at beat 4
    clr_cap();
    do_load(K1, 1'b1);
    lat = 0;
    while (n_beats < 4 && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("beat4_timeout", 128'(n_beats), 128'(4));
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_str");
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr_cap();
    do_load(K2, 1'b1);
    run_done(1'b0, 40);
    chk("beats_d", 128'(n_beats), 128'(11));
    chk("d_r10", cap[10], K2_10);
    chk("d_r0",  cap[0],  K2);

    // load coincident with the round-0 acceptance is ignored
    do_load(K1, 1'b1);
    wait_last(40);
    u_if.key_in   = K2;
    u_if.key_load = 1'b1;
    @(posedge clk); #1;
    u_if.key_load = 1'b0;
    chk("coinc_busy",  128'(u_if.busy),     128'(0));
    chk("coinc_valid", 128'(u_if.rk_valid), 128'(0));

    // back-to-back: load one cycle after round-0 acceptance is taken
    do_load(K1, 1'b1);
    wait_last(40);
    @(posedge clk); #1;
    clr_cap();
    do_load(K2, 1'b1);
    chk("b2b_busy", 128'(u_if.busy), 128'(1));
    run_done(1'b0, 40);
    chk("beats_e", 128'(n_beats), 128'(11));
    chk("e_r10", cap[10], K2_10);
    chk("e_r0",  cap[0],  K2);
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
